// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks destination masks of in-flight
// instructions (EX..WB) and stalls decode on read-after-write conflicts.

module hs_stage #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int FORWARD = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [30:0]      id_rmask,
  input  logic [30:0]      id_wmask,
  input  logic             id_load,
  input  logic             hold,
  input  logic             kill_ex,
  output logic             id_ready,
  output logic [30:0]      pending,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic        v;
    logic [30:0] wm;
    logic        ld;
  } ent_t;

  ent_t ent_q [STAGES];
  ent_t ent_d [STAGES];

  logic             hazard;
  logic             issue;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // WB is excluded: the register file writes before it reads.
  always_comb begin
    pending = '0;
    for (int i = 0; i < STAGES-1; i++)
      if (ent_q[i].v) pending = pending | ent_q[i].wm;
  end

  generate
    if (FORWARD != 0) begin : g_fwd
      assign hazard = ent_q[0].v & ent_q[0].ld & (|(id_rmask & ent_q[0].wm));
    end else begin : g_nofwd
      assign hazard = |(id_rmask & pending);
    end
  endgenerate

  assign id_ready = id_valid & ~hazard & ~hold;
  assign issue    = id_ready;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stg
      if (g == 0) begin : g_ex
        assign ent_d[g] = '{v: issue, wm: issue ? id_wmask : '0, ld: issue & id_load};
      end else if (g == 1) begin : g_mem
        // A squashed EX entry moves on as a bubble.
        assign ent_d[g] = kill_ex ? '0 : ent_q[g-1];
      end else begin : g_tail
        assign ent_d[g] = ent_q[g-1];
      end
      hs_stage #(.W($bits(ent_t))) u_stg (
        .clk   (clk),
        .reset (reset),
        .en_i  (~hold),
        .d_i   (ent_d[g]),
        .q_o   (ent_q[g])
      );
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (id_valid & hazard & ~hold & (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;

  // The retiring entry and load flags past EX feed nothing.
  logic unused_bits;
  always_comb begin
    unused_bits = ^ent_q[STAGES-1];
    for (int i = 1; i < STAGES; i++) unused_bits = unused_bits ^ ent_q[i].ld;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a forwarding instance and a non-forwarding 4-bit-counter
// instance share one stimulus; each step checks the instance it targets.

module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [30:0] id_rmask = '0;
  logic [30:0] id_wmask = '0;
  logic        id_load = 1'b0;
  logic        hold = 1'b0;
  logic        kill_ex = 1'b0;

  logic        rdy_fw, rdy_nf;
  logic [30:0] pend_fw, pend_nf;
  logic [15:0] cnt_fw;
  logic [3:0]  cnt_nf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .FORWARD(1), .CNT_W(16)) u_fw (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rmask(id_rmask),
    .id_wmask(id_wmask), .id_load(id_load), .hold(hold), .kill_ex(kill_ex),
    .id_ready(rdy_fw), .pending(pend_fw), .stall_count(cnt_fw));

  hazard_scoreboard #(.STAGES(3), .FORWARD(0), .CNT_W(4)) u_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rmask(id_rmask),
    .id_wmask(id_wmask), .id_load(id_load), .hold(hold), .kill_ex(kill_ex),
    .id_ready(rdy_nf), .pending(pend_nf), .stall_count(cnt_nf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; #1; reset = 1'b0; #1;
  endtask

  task automatic drive(input logic v, input logic [30:0] rm, input logic [30:0] wm, input logic ld);
    id_valid = v; id_rmask = rm; id_wmask = wm; id_load = ld; #1;
  endtask

  initial begin
    #12 reset = 1'b0;

    // reset state, first-cycle issue
    drive(1, 31'h1, 31'h0, 0);
    check("rst_rdy_fw", rdy_fw, 1);
    check("rst_rdy_nf", rdy_nf, 1);
    check("rst_pend", pend_fw, 0);
    check("rst_cnt", cnt_fw, 0);

    // FORWARD=1 load-use: exactly one stall
    pulse_reset();
    drive(1, 31'h0, 31'h80, 1);
    check("lu_lw_rdy", rdy_fw, 1);
    tick();
    drive(1, 31'h80, 31'h100, 0);
    check("lu_stall_rdy", rdy_fw, 0);
    check("lu_stall_pend", pend_fw, 32'h80);
    tick();
    check("lu_go_rdy", rdy_fw, 1);
    check("lu_go_pend", pend_fw, 32'h80);
    check("lu_cnt", cnt_fw, 1);
    tick();
    check("lu_cnt_after", cnt_fw, 1);
    drive(0, 0, 0, 0);

    // FORWARD=0: two stalls behind a back-to-back producer
    pulse_reset();
    drive(1, 31'h0, 31'h8, 0);
    check("nf_addi_rdy", rdy_nf, 1);
    tick();
    drive(1, 31'h8, 31'h0, 0);
    check("nf_stall1_rdy", rdy_nf, 0);
    check("nf_stall1_pend", pend_nf, 32'h8);
    tick();
    check("nf_stall2_rdy", rdy_nf, 0);
    check("nf_stall2_pend", pend_nf, 32'h8);
    tick();
    check("nf_go_rdy", rdy_nf, 1);
    check("nf_go_pend", pend_nf, 0);
    check("nf_cnt", cnt_nf, 2);
    tick();
    drive(0, 0, 0, 0);

    // hold freezes state and counter
    pulse_reset();
    drive(1, 31'h0, 31'h80, 1);
    tick();
    drive(1, 31'h80, 31'h0, 0);
    hold = 1'b1; #1;
    check("hold_rdy", rdy_fw, 0);
    for (int i = 0; i < 4; i++) tick();
    check("hold_pend", pend_fw, 32'h80);
    check("hold_rdy4", rdy_fw, 0);
    check("hold_cnt", cnt_fw, 0);
    hold = 1'b0; #1;
    check("unhold_rdy", rdy_fw, 0);
    tick();
    check("unhold_go", rdy_fw, 1);
    check("unhold_cnt", cnt_fw, 1);
    tick();
    drive(0, 0, 0, 0);

    // kill_ex turns the stalled-on producer into a bubble
    pulse_reset();
    drive(1, 31'h0, 31'h80, 1);
    check("kill_lw_rdy", rdy_nf, 1);
    tick();
    drive(1, 31'h80, 31'h0, 0);
    kill_ex = 1'b1; #1;
    check("kill_stall_rdy", rdy_nf, 0);
    tick();
    kill_ex = 1'b0; #1;
    check("kill_rdy", rdy_nf, 1);
    check("kill_pend", pend_nf, 0);
    check("kill_cnt", cnt_nf, 1);
    drive(0, 0, 0, 0);

    // saturation: self-dependent stream stalls 2 of every 3 edges
    pulse_reset();
    drive(1, 31'h1, 31'h1, 0);
    for (int i = 0; i < 15; i++) tick();
    check("sat_mid_cnt", cnt_nf, 10);
    for (int i = 0; i < 15; i++) tick();
    check("sat_cnt", cnt_nf, 15);
    tick();
    check("sat_hold_cnt", cnt_nf, 15);
    check("sat_pend", pend_nf, 1);
    reset = 1'b1; #1;
    check("async_pend", pend_nf, 0);
    check("async_cnt", cnt_nf, 0);
    check("async_rdy", rdy_nf, 1);
    reset = 1'b0;
    drive(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
